omni_tx_sender: RTL
===================

# omni_tx_sender

Downstream stage of the omni slot: consumes the 528-bit `{session_id, payload}` words the slot emits and pushes each one onto the TCP/IP stack's transmit interface. For each word it issues a TX metadata request, waits for the stack's TX status, and on success sends the 64-byte payload as a single-beat data packet. Rejected requests are retried after a fixed backoff, up to a bounded count, after which the word is dropped and counted. One word is in flight at a time.

## Interface
Parameters:
- `PKT_BYTES`, 64: payload length placed in every metadata request; fixed to one 512-bit beat.
- `MAX_RETRY`, 8: number of rejected status responses tolerated per word before it is dropped.
- `BACKOFF_CYCLES`, 16: idle cycles between a rejected status and the re-issued metadata request.

Ports (all AXI-Stream, valid/ready):
- `clk`  in  1: single clock.
- `rst`  in  1: reset, synchronous, active-high.
- `rx_TDATA`  in  528: `[527:512]` session_id, `[511:0]` payload.
- `rx_TVALID`  in  1: input word valid.
- `rx_TREADY`  out  1: input word accepted.
- `m_axis_tx_meta_TDATA`  out  32: `[15:0]` session_id, `[31:16]` length.
- `m_axis_tx_meta_TVALID`  out  1; `m_axis_tx_meta_TREADY`  in  1.
- `s_axis_tx_status_TDATA`  in  64: `[15:0]` session_id, `[31:16]` length, `[61:32]` remaining space, `[63:62]` error.
- `s_axis_tx_status_TVALID`  in  1; `s_axis_tx_status_TREADY`  out  1.
- `m_axis_tx_data_TDATA`  out  512: payload.
- `m_axis_tx_data_TKEEP`  out  64: all ones.
- `m_axis_tx_data_TLAST`  out  1: always 1 while valid.
- `m_axis_tx_data_TVALID`  out  1; `m_axis_tx_data_TREADY`  in  1.
- `sent_count`  out  32: words successfully sent; wraps modulo 2^32.
- `drop_count`  out  32: words dropped after `MAX_RETRY` rejections; wraps modulo 2^32.

## Operation
- FSM states: IDLE, META, STATUS, BACKOFF, DATA.
- IDLE: `rx_TREADY`=1. On `rx_TVALID`, latch session_id and payload, clear the retry count, and go to META.
- META: `tx_meta_TVALID`=1 with `{PKT_BYTES[15:0], session_id}`. Data is held stable until accepted. On acceptance, go to STATUS.
- STATUS: `tx_status_TREADY`=1. On a status beat:
  - Success requires error==0, session_id equal to the latched id, and length==`PKT_BYTES`. On success, go to DATA.
  - Otherwise increment the retry count. If the count reaches `MAX_RETRY`, increment `drop_count` and go to IDLE. Else load the backoff counter with `BACKOFF_CYCLES-1` and go to BACKOFF.
- BACKOFF: decrement the counter each cycle; at 0, go to META.
- DATA: `tx_data_TVALID`=1, TKEEP all ones, TLAST=1, payload held stable. On acceptance, increment `sent_count` and go to IDLE.
- Ready signals are Moore (decoded from state only). Valid is never dropped before the matching ready.
- Retry counter width is `$clog2(MAX_RETRY+1)`. Backoff counter width is `$clog2(BACKOFF_CYCLES)`, minimum 1.

## Timing
- Reset values: state IDLE, all TVALID outputs 0, `tx_status_TREADY` 0, `rx_TREADY` 0 during the reset cycle, both counters 0, data outputs 0.
- Reset asserted mid-operation discards the latched word without counting it; no partial handshake completes.
- Best case (rx accepted at T, all readys high, status arrives at T+2):
  - meta valid T+1;
  - status taken T+2;
  - data valid T+3;
  - `rx_TREADY` high again T+4.
  - Throughput is one word per 4 cycles.
- A status beat arriving while not in STATUS is not consumed (TREADY=0).
- `sent_count`/`drop_count` update the cycle after the triggering handshake.
- Each failed attempt adds 1 (status) + `BACKOFF_CYCLES` + 1 (meta) cycles minimum.

## Structure
- Shared package `omni_pkg`:
  - width constants (`OMNI_META_W`=16, `OMNI_PAYLOAD_W`=512, `TCP_META_W`=32, `TCP_STATUS_W`=64);
  - status field offsets;
  - FSM state enum.
- No sub-module; a single FSM with a datapath register.

## Test plan
- Single word, session 0x0005, all readys high, status error=0 → meta 0x0040_0005 at T+1, data beat with TLAST=1 and TKEEP=all-ones at T+3, `sent_count`=1.
- Status error=1 once, then error=0 → exactly 17 cycles between the first meta handshake completing and the second meta valid, one data beat, `sent_count`=1, `drop_count`=0.
- Status error=2 eight times → no data beat, `drop_count`=1, `rx_TREADY` high the cycle after the 8th status.
- Status session_id 0x0006 for latched id 0x0005 → treated as a rejection, meta re-issued after backoff.
- `tx_meta_TREADY`/`tx_data_TREADY` randomly toggled over 100 words → TDATA stable while valid&!ready, payloads arrive in order, `sent_count`=100.
- `rst` pulsed for 1 cycle while in DATA → TVALID low the next cycle, counters 0, next word processed normally.

Source files
------------

// File: rtl/omni_pkg.sv
// Shared widths, status field layout and FSM states
// for the omni slot transmit path.
package omni_pkg;

  localparam int OMNI_META_W    = 16;
  localparam int OMNI_PAYLOAD_W = 512;
  localparam int OMNI_WORD_W    = OMNI_META_W + OMNI_PAYLOAD_W;
  localparam int TCP_META_W     = 32;
  localparam int TCP_STATUS_W   = 64;

  localparam int ST_SID_LSB   = 0;
  localparam int ST_SID_W     = 16;
  localparam int ST_LEN_LSB   = 16;
  localparam int ST_LEN_W     = 16;
  localparam int ST_SPACE_LSB = 32;
  localparam int ST_SPACE_W   = 30;
  localparam int ST_ERR_LSB   = 62;
  localparam int ST_ERR_W     = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_META,
    ST_STATUS,
    ST_BACKOFF,
    ST_DATA
  } tx_state_e;

  // A status beat accepts the request only if it is error-free
  // and echoes both our session and our length.
  function automatic logic status_ok(
    input logic [TCP_STATUS_W-1:0] st,
    input logic [ST_SID_W-1:0]     sid,
    input logic [ST_LEN_W-1:0]     len
  );
    return (st[ST_ERR_LSB +: ST_ERR_W] == '0)
        && (st[ST_SID_LSB +: ST_SID_W] == sid)
        && (st[ST_LEN_LSB +: ST_LEN_W] == len);
  endfunction

endpackage

// File: rtl/omni_tx_sender.sv
// Pushes omni slot words onto the TCP TX interface:
// meta request, status wait with bounded retry, data beat.
module omni_tx_sender
  import omni_pkg::*;
#(
  parameter int PKT_BYTES      = 64,
  parameter int MAX_RETRY      = 8,
  parameter int BACKOFF_CYCLES = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [OMNI_WORD_W-1:0]    rx_TDATA,
  input  logic                      rx_TVALID,
  output logic                      rx_TREADY,
  output logic [TCP_META_W-1:0]     m_axis_tx_meta_TDATA,
  output logic                      m_axis_tx_meta_TVALID,
  input  logic                      m_axis_tx_meta_TREADY,
  input  logic [TCP_STATUS_W-1:0]   s_axis_tx_status_TDATA,
  input  logic                      s_axis_tx_status_TVALID,
  output logic                      s_axis_tx_status_TREADY,
  output logic [OMNI_PAYLOAD_W-1:0] m_axis_tx_data_TDATA,
  output logic [OMNI_PAYLOAD_W/8-1:0] m_axis_tx_data_TKEEP,
  output logic                      m_axis_tx_data_TLAST,
  output logic                      m_axis_tx_data_TVALID,
  input  logic                      m_axis_tx_data_TREADY,
  output logic [31:0]               sent_count,
  output logic [31:0]               drop_count
);

  localparam int RW = $clog2(MAX_RETRY + 1);
  localparam int BW = (BACKOFF_CYCLES > 1) ?
                      $clog2(BACKOFF_CYCLES) : 1;
  localparam logic [ST_LEN_W-1:0] LEN = ST_LEN_W'(PKT_BYTES);

  tx_state_e state_q, state_d;
  logic [OMNI_META_W-1:0]    sid_q;
  logic [OMNI_PAYLOAD_W-1:0] pay_q;
  logic [RW-1:0] retry_q, retry_d, retry_inc;
  logic [BW-1:0] boff_q, boff_d;
  logic [31:0]   sent_q, drop_q;

  logic rx_hs, meta_hs, st_hs, data_hs;
  logic st_good, sent_evt, drop_evt;
  logic unused_space;

  // Remaining-space field is informational only.
  assign unused_space =
    ^s_axis_tx_status_TDATA[ST_SPACE_LSB +: ST_SPACE_W];

  // Moore handshakes; reset masks everything so nothing
  // half-completes in the reset cycle.
  assign rx_TREADY = ~rst & (state_q == ST_IDLE);
  assign m_axis_tx_meta_TVALID = ~rst & (state_q == ST_META);
  assign s_axis_tx_status_TREADY =
    ~rst & (state_q == ST_STATUS);
  assign m_axis_tx_data_TVALID = ~rst & (state_q == ST_DATA);

  assign m_axis_tx_meta_TDATA = m_axis_tx_meta_TVALID ?
                                {LEN, sid_q} : '0;
  assign m_axis_tx_data_TDATA = m_axis_tx_data_TVALID ?
                                pay_q : '0;
  assign m_axis_tx_data_TKEEP =
    {(OMNI_PAYLOAD_W/8){m_axis_tx_data_TVALID}};
  assign m_axis_tx_data_TLAST = m_axis_tx_data_TVALID;

  assign sent_count = sent_q;
  assign drop_count = drop_q;

  assign rx_hs   = rx_TVALID & rx_TREADY;
  assign meta_hs = m_axis_tx_meta_TVALID & m_axis_tx_meta_TREADY;
  assign st_hs   = s_axis_tx_status_TVALID
                 & s_axis_tx_status_TREADY;
  assign data_hs = m_axis_tx_data_TVALID & m_axis_tx_data_TREADY;

  assign st_good   = status_ok(s_axis_tx_status_TDATA, sid_q, LEN);
  assign retry_inc = retry_q + RW'(1);

  // Next-state, retry and backoff bookkeeping.
  always_comb begin
    state_d  = state_q;
    retry_d  = retry_q;
    boff_d   = boff_q;
    sent_evt = 1'b0;
    drop_evt = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (rx_hs) begin
          state_d = ST_META;
          retry_d = '0;
        end
      end
      ST_META: begin
        if (meta_hs) state_d = ST_STATUS;
      end
      ST_STATUS: begin
        if (st_hs) begin
          if (st_good) begin
            state_d = ST_DATA;
          end else begin
            retry_d = retry_inc;
            if (retry_inc == RW'(MAX_RETRY)) begin
              drop_evt = 1'b1;
              state_d  = ST_IDLE;
            end else begin
              boff_d  = BW'(BACKOFF_CYCLES - 1);
              state_d = ST_BACKOFF;
            end
          end
        end
      end
      ST_BACKOFF: begin
        if (boff_q == '0) state_d = ST_META;
        else boff_d = boff_q - BW'(1);
      end
      ST_DATA: begin
        if (data_hs) begin
          sent_evt = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, latched word and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sid_q   <= '0;
      pay_q   <= '0;
      retry_q <= '0;
      boff_q  <= '0;
      sent_q  <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      retry_q <= retry_d;
      boff_q  <= boff_d;
      if (rx_hs) begin
        sid_q <= rx_TDATA[OMNI_WORD_W-1 -: OMNI_META_W];
        pay_q <= rx_TDATA[OMNI_PAYLOAD_W-1:0];
      end
      if (sent_evt) sent_q <= sent_q + 32'd1;
      if (drop_evt) drop_q <= drop_q + 32'd1;
    end
  end

endmodule
